store_rmw_ctrl: RTL and testbench
=================================

# store_rmw_ctrl

Read-modify-write sequencer for sub-word stores in the multicycle datapath. On a store request it reads the addressed memory word into its MDR register and hands that word and the register operand to the `store_size` merge stage. It then captures the merged word and writes it back to memory. Full-word stores bypass the read. The block sits between the control unit and the data memory, directly upstream and downstream of `store_size`.

## Interface
- `MEM_LAT`, default 1, memory read latency in cycles; legal range 1..15.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: store request; sampled only in IDLE.
- `is_word` in 1: 1 = full-word store (no read); sampled with `start`.
- `addr` in 32: store address; sampled with `start`.
- `b` in 32: register operand; sampled with `start`.
- `mem_rdata` in 32: memory read data.
- `merged_in` in 32: merged word returned from `store_size`.
- `mem_addr` out 32: memory address, equal to the latched address `addr_q`.
- `mem_rd` out 1: memory read strobe.
- `mem_wr` out 1: memory write strobe.
- `mem_wdata` out 32: write data, equal to `wdata_q`.
- `mdr` out 32: latched memory word `mdr_q`; drives the `mdr` input of `store_size`.
- `b_q` out 32: latched operand; drives the `b` input of `store_size`.
- `busy` out 1: high in READ, MERGE and WRITE.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, READ, MERGE, WRITE, DONE.
- IDLE:
  - If `start`=1 and `is_word`=0: latch `addr_q`<=`addr` and `b_q`<=`b`, clear the latency counter `cnt`<=0, go to READ.
  - If `start`=1 and `is_word`=1: latch `addr_q`<=`addr`, `b_q`<=`b` and `wdata_q`<=`b`, go to WRITE.
  - Otherwise stay in IDLE.
- READ:
  - `mem_rd`=1 every cycle; `mem_addr` held stable.
  - While `cnt` < `MEM_LAT`: `cnt` increments by 1.
  - When `cnt` == `MEM_LAT`: `mdr_q`<=`mem_rdata`, go to MERGE.
  - READ therefore lasts `MEM_LAT`+1 cycles. `cnt` is 4 bits wide and never wraps within the legal range.
- MERGE: `wdata_q`<=`merged_in`, go to WRITE. `merged_in` is combinational from `mdr_q` and `b_q` and is valid for this whole cycle.
- WRITE: `mem_wr`=1 for exactly one cycle, with `mem_wdata`=`wdata_q` and `mem_addr`=`addr_q`; go to DONE.
- DONE: `done`=1, `busy`=0; go to IDLE unconditionally.
- `start` is ignored in READ, MERGE, WRITE and DONE. It is not queued, so a request raised there must be re-asserted in IDLE.
- `mem_rd` and `mem_wr` are never high in the same cycle.
- `is_word`, `addr` and `b` may change freely after the start cycle; only the latched copies are used.

## Timing
- Reset values: state IDLE, `cnt`=0. `addr_q`, `b_q`, `mdr_q` and `wdata_q` are all 0. `mem_rd`, `mem_wr`, `busy` and `done` are all 0.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- Sub-word store, with `start` high in cycle 0:
  - READ occupies cycles 1..`MEM_LAT`+1.
  - MERGE is cycle `MEM_LAT`+2.
  - WRITE is cycle `MEM_LAT`+3.
  - DONE is cycle `MEM_LAT`+4.
  - With `MEM_LAT`=1, `mem_wr` is high in cycle 4 and `done` in cycle 5.
- Word store, with `start` high in cycle 0: WRITE in cycle 1, DONE in cycle 2.
- Back-to-back requests: the earliest next accepted `start` is in the cycle after DONE, when the block is back in IDLE.
- Reset asserted in any state: the next state is IDLE with all reset values. Any in-progress write is aborted, and `mem_wr` is low from the cycle after the reset edge.
- `reset` and `start` high in the same cycle: reset wins, and the request is dropped.

## Test plan
- Reset, then idle for 5 cycles -> all outputs 0; `mem_rd`=`mem_wr`=0 throughout.
- `MEM_LAT`=1; `start`, `is_word`=0, `addr`=0x40, `b`=0x00000000; memory returns 0xAABBCCDD; bench models `store_size` (b[0]=0, byte) -> `mem_rd` high in cycles 1-2; `mdr`=0xAABBCCDD from cycle 3; `mem_wr` high in cycle 4 with `mem_wdata`=0xAABBCC00 and `mem_addr`=0x40; `done` high in cycle 5 only.
- `MEM_LAT`=3; `b`=0x00001235 (b[0]=1, halfword); memory returns 0x11223344 -> `mem_rd` high in cycles 1-4; `mem_wr` high in cycle 6 with `mem_wdata`=0x11221235; `done` high in cycle 7.
- `is_word`=1, `b`=0xDEADBEEF, `addr`=0x80 -> `mem_rd` never high; `mem_wr` high in cycle 1 with `mem_wdata`=0xDEADBEEF; `done` high in cycle 2.
- `start` re-pulsed in cycles 2 and 4 of a sub-word store with different `addr`/`b` -> exactly one write, using the original `addr`/`b`; `busy`=1 in cycles 1-4.
- `reset` asserted in the MERGE cycle -> `mem_wr` never asserted; state IDLE and all outputs 0 in the following cycle; a new `start` two cycles later completes normally.

Source files
------------

// File: rtl/store_rmw_if.sv
// Bus bundle for the store read-modify-write sequencer: control request,
// data-memory port and the side channel to the store_size merge stage.
interface store_rmw_if;
    logic        start;
    logic        is_word;
    logic [31:0] addr;
    logic [31:0] b;
    logic [31:0] mem_rdata;
    logic [31:0] merged_in;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mdr;
    logic [31:0] b_q;
    logic        busy;
    logic        done;

    modport master (
        output start, is_word, addr, b, mem_rdata, merged_in,
        input  mem_addr, mem_rd, mem_wr, mem_wdata, mdr, b_q, busy, done
    );

    modport slave (
        input  start, is_word, addr, b, mem_rdata, merged_in,
        output mem_addr, mem_rd, mem_wr, mem_wdata, mdr, b_q, busy, done
    );
endinterface

// File: rtl/store_rmw_ctrl.sv
// Read-modify-write sequencer for sub-word stores. Sub-word stores read the
// addressed word into the MDR, let store_size merge the operand into it, then
// write the merged word back. Full-word stores go straight to the write.
// All strobes are registered from the next-state decode, so nothing on the
// bus side is combinational from the inputs.
module store_rmw_ctrl #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    store_rmw_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Read wait length; cnt counts 0..LAT so READ lasts LAT+1 cycles.
    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] b_r, b_s;
    logic [31:0] mdr_r, mdr_s;
    logic [31:0] wdata_r, wdata_s;
    logic        mem_rd_r, mem_rd_s;
    logic        mem_wr_r, mem_wr_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;

    // Next-state and datapath-latch selection for the sequencer.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        addr_s  = addr_r;
        b_s     = b_r;
        mdr_s   = mdr_r;
        wdata_s = wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    addr_s = bus.addr;
                    b_s    = bus.b;
                    if (bus.is_word) begin
                        wdata_s = bus.b;
                        state_s = ST_WRITE;
                    end else begin
                        cnt_s   = 4'd0;
                        state_s = ST_READ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (cnt_r < LAT) begin
                    cnt_s = cnt_r + 4'd1;
                end else begin
                    mdr_s   = bus.mem_rdata;
                    state_s = ST_MERGE;
                end
            end
            ST_MERGE: begin
                wdata_s = bus.merged_in;
                state_s = ST_WRITE;
            end
            ST_WRITE: begin
                state_s = ST_DONE;
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Strobe decode from the upcoming state so the strobes come out of flops.
    always_comb begin
        mem_rd_s = 1'b0;
        mem_wr_s = 1'b0;
        busy_s   = 1'b0;
        done_s   = 1'b0;
        case (state_s)
            ST_IDLE:  begin end
            ST_READ:  begin mem_rd_s = 1'b1; busy_s = 1'b1; end
            ST_MERGE: begin busy_s = 1'b1; end
            ST_WRITE: begin mem_wr_s = 1'b1; busy_s = 1'b1; end
            ST_DONE:  begin done_s = 1'b1; end
            default:  begin end
        endcase
    end

    // State, datapath latches and strobes; reset aborts any transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            addr_r   <= 32'd0;
            b_r      <= 32'd0;
            mdr_r    <= 32'd0;
            wdata_r  <= 32'd0;
            mem_rd_r <= 1'b0;
            mem_wr_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            addr_r   <= addr_s;
            b_r      <= b_s;
            mdr_r    <= mdr_s;
            wdata_r  <= wdata_s;
            mem_rd_r <= mem_rd_s;
            mem_wr_r <= mem_wr_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign bus.mem_addr  = addr_r;
    assign bus.mem_rd    = mem_rd_r;
    assign bus.mem_wr    = mem_wr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.mdr       = mdr_r;
    assign bus.b_q       = b_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Directed bench for store_rmw_ctrl: one DUT with MEM_LAT=1, one with
// MEM_LAT=3. The store_size merge stage is modelled in the bench.
module tb_store_rmw_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    store_rmw_if bus1();
    store_rmw_if bus3();

    store_rmw_ctrl #(.MEM_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    store_rmw_ctrl #(.MEM_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    // Status vector encodings {mem_rd, mem_wr, busy, done}
    localparam logic [3:0] V_IDLE  = 4'b0000;
    localparam logic [3:0] V_READ  = 4'b1010;
    localparam logic [3:0] V_MERGE = 4'b0010;
    localparam logic [3:0] V_WRITE = 4'b0110;
    localparam logic [3:0] V_DONE  = 4'b0001;

    // store_size model: b[0]=1 merges a halfword, b[0]=0 merges a byte.
    always_comb begin
        bus1.merged_in = bus1.b_q[0] ? {bus1.mdr[31:16], bus1.b_q[15:0]}
                                     : {bus1.mdr[31:8],  bus1.b_q[7:0]};
        bus3.merged_in = bus3.b_q[0] ? {bus3.mdr[31:16], bus3.b_q[15:0]}
                                     : {bus3.mdr[31:8],  bus3.b_q[7:0]};
    end

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] v;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            v = {bus1.mem_rd, bus1.mem_wr, bus1.busy, bus1.done};
            checks++;
            if (v !== V_IDLE) begin
                errors++;
                $display("FAIL reset_strobes cycle %0d: got %b expected %b", k, v, V_IDLE);
            end
            tick();
        end
        checks++;
        if ({bus1.mem_addr, bus1.mem_wdata, bus1.mdr, bus1.b_q} !== 128'd0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h mdr=%h b_q=%h expected all 0",
                     bus1.mem_addr, bus1.mem_wdata, bus1.mdr, bus1.b_q);
        end
        checks++;
        if ({bus3.mem_rd, bus3.mem_wr, bus3.busy, bus3.done, bus3.mdr} !== 36'd0) begin
            errors++;
            $display("FAIL reset_dut3: rd=%b wr=%b busy=%b done=%b mdr=%h expected 0",
                     bus3.mem_rd, bus3.mem_wr, bus3.busy, bus3.done, bus3.mdr);
        end
    endtask

    task automatic test_byte_lat1();
        logic [3:0] v, e;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin
                bus1.start = 1'b1; bus1.is_word = 1'b0;
                bus1.addr = 32'h0000_0040; bus1.b = 32'h0000_0000;
                bus1.mem_rdata = 32'hAABB_CCDD;
            end else begin
                bus1.start = 1'b0;
            end
            e = (k == 1 || k == 2) ? V_READ : (k == 3) ? V_MERGE :
                (k == 4) ? V_WRITE : (k == 5) ? V_DONE : V_IDLE;
            v = {bus1.mem_rd, bus1.mem_wr, bus1.busy, bus1.done};
            checks++;
            if (v !== e) begin
                errors++;
                $display("FAIL byte_lat1_strobes cycle %0d: got %b expected %b", k, v, e);
            end
            if (k == 3) begin
                checks++;
                if (bus1.mdr !== 32'hAABB_CCDD) begin
                    errors++;
                    $display("FAIL byte_lat1_mdr: got %h expected aabbccdd", bus1.mdr);
                end
            end
            if (k == 4) begin
                checks++;
                if (bus1.mem_wdata !== 32'hAABB_CC00 || bus1.mem_addr !== 32'h0000_0040) begin
                    errors++;
                    $display("FAIL byte_lat1_write: wdata=%h addr=%h expected aabbcc00/00000040",
                             bus1.mem_wdata, bus1.mem_addr);
                end
            end
            tick();
        end
    endtask

    task automatic test_half_lat3();
        logic [3:0] v, e;
        for (int k = 0; k < 10; k++) begin
            if (k == 0) begin
                bus3.start = 1'b1; bus3.is_word = 1'b0;
                bus3.addr = 32'h0000_0044; bus3.b = 32'h0000_1235;
                bus3.mem_rdata = 32'h1122_3344;
            end else begin
                bus3.start = 1'b0;
            end
            e = (k >= 1 && k <= 4) ? V_READ : (k == 5) ? V_MERGE :
                (k == 6) ? V_WRITE : (k == 7) ? V_DONE : V_IDLE;
            v = {bus3.mem_rd, bus3.mem_wr, bus3.busy, bus3.done};
            checks++;
            if (v !== e) begin
                errors++;
                $display("FAIL half_lat3_strobes cycle %0d: got %b expected %b", k, v, e);
            end
            if (k == 6) begin
                checks++;
                if (bus3.mem_wdata !== 32'h1122_1235 || bus3.mem_addr !== 32'h0000_0044) begin
                    errors++;
                    $display("FAIL half_lat3_write: wdata=%h addr=%h expected 11221235/00000044",
                             bus3.mem_wdata, bus3.mem_addr);
                end
            end
            tick();
        end
    endtask

    task automatic test_word();
        logic [3:0] v, e;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                bus1.start = 1'b1; bus1.is_word = 1'b1;
                bus1.addr = 32'h0000_0080; bus1.b = 32'hDEAD_BEEF;
                bus1.mem_rdata = 32'h0BAD_0BAD;
            end else begin
                bus1.start = 1'b0; bus1.is_word = 1'b0;
                bus1.b = 32'h0;
            end
            e = (k == 1) ? V_WRITE : (k == 2) ? V_DONE : V_IDLE;
            v = {bus1.mem_rd, bus1.mem_wr, bus1.busy, bus1.done};
            checks++;
            if (v !== e) begin
                errors++;
                $display("FAIL word_strobes cycle %0d: got %b expected %b", k, v, e);
            end
            if (k == 1) begin
                checks++;
                if (bus1.mem_wdata !== 32'hDEAD_BEEF || bus1.mem_addr !== 32'h0000_0080) begin
                    errors++;
                    $display("FAIL word_write: wdata=%h addr=%h expected deadbeef/00000080",
                             bus1.mem_wdata, bus1.mem_addr);
                end
            end
            tick();
        end
    endtask

    task automatic test_start_ignored();
        logic [3:0] v, e;
        int writes;
        writes = 0;
        for (int k = 0; k < 10; k++) begin
            bus1.start = 1'b0;
            if (k == 0) begin
                bus1.start = 1'b1; bus1.is_word = 1'b0;
                bus1.addr = 32'h0000_0100; bus1.b = 32'h0000_00AA;
                bus1.mem_rdata = 32'h0102_0304;
            end else if (k == 2) begin
                bus1.start = 1'b1; bus1.addr = 32'h0000_0200; bus1.b = 32'h0000_FFFF;
            end else if (k == 4) begin
                bus1.start = 1'b1; bus1.addr = 32'h0000_0300; bus1.b = 32'h0000_5555;
            end
            e = (k == 1 || k == 2) ? V_READ : (k == 3) ? V_MERGE :
                (k == 4) ? V_WRITE : (k == 5) ? V_DONE : V_IDLE;
            v = {bus1.mem_rd, bus1.mem_wr, bus1.busy, bus1.done};
            checks++;
            if (v !== e) begin
                errors++;
                $display("FAIL ignore_strobes cycle %0d: got %b expected %b", k, v, e);
            end
            if (bus1.mem_wr === 1'b1) writes++;
            if (k == 4) begin
                checks++;
                if (bus1.mem_wdata !== 32'h0102_03AA || bus1.mem_addr !== 32'h0000_0100) begin
                    errors++;
                    $display("FAIL ignore_write: wdata=%h addr=%h expected 010203aa/00000100",
                             bus1.mem_wdata, bus1.mem_addr);
                end
            end
            tick();
        end
        bus1.start = 1'b0;
        checks++;
        if (writes !== 1) begin
            errors++;
            $display("FAIL ignore_write_count: got %0d expected 1", writes);
        end
    endtask

    task automatic test_reset_merge();
        logic [3:0] v, e;
        for (int k = 0; k < 12; k++) begin
            bus1.start = 1'b0;
            reset = 1'b0;
            if (k == 0) begin
                bus1.start = 1'b1; bus1.is_word = 1'b0;
                bus1.addr = 32'h0000_0040; bus1.b = 32'h0000_0022;
                bus1.mem_rdata = 32'h5566_7788;
            end else if (k == 3) begin
                reset = 1'b1;
            end else if (k == 5) begin
                bus1.start = 1'b1; bus1.is_word = 1'b0;
                bus1.addr = 32'h0000_0060; bus1.b = 32'h0000_0034;
                bus1.mem_rdata = 32'h99AA_BBCC;
            end
            e = (k == 1 || k == 2) ? V_READ : (k == 3) ? V_MERGE :
                (k == 6 || k == 7) ? V_READ : (k == 8) ? V_MERGE :
                (k == 9) ? V_WRITE : (k == 10) ? V_DONE : V_IDLE;
            v = {bus1.mem_rd, bus1.mem_wr, bus1.busy, bus1.done};
            checks++;
            if (v !== e) begin
                errors++;
                $display("FAIL rstmerge_strobes cycle %0d: got %b expected %b", k, v, e);
            end
            if (k == 4) begin
                checks++;
                if ({bus1.mem_addr, bus1.mem_wdata, bus1.mdr, bus1.b_q} !== 128'd0) begin
                    errors++;
                    $display("FAIL rstmerge_cleared: addr=%h wdata=%h mdr=%h b_q=%h expected all 0",
                             bus1.mem_addr, bus1.mem_wdata, bus1.mdr, bus1.b_q);
                end
            end
            if (k == 9) begin
                checks++;
                if (bus1.mem_wdata !== 32'h99AA_BB34 || bus1.mem_addr !== 32'h0000_0060) begin
                    errors++;
                    $display("FAIL rstmerge_write: wdata=%h addr=%h expected 99aabb34/00000060",
                             bus1.mem_wdata, bus1.mem_addr);
                end
            end
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic test_reset_start();
        logic [3:0] v;
        bus1.start = 1'b1; bus1.is_word = 1'b1;
        bus1.addr = 32'h0000_00F0; bus1.b = 32'h1234_5678;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus1.start = 1'b0; bus1.is_word = 1'b0;
        for (int k = 1; k < 4; k++) begin
            v = {bus1.mem_rd, bus1.mem_wr, bus1.busy, bus1.done};
            checks++;
            if (v !== V_IDLE || bus1.mem_addr !== 32'd0) begin
                errors++;
                $display("FAIL reset_start_drop cycle %0d: got %b addr=%h expected 0000/00000000",
                         k, v, bus1.mem_addr);
            end
            tick();
        end
    endtask

    // Test sequence.
    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus1.start = 1'b0; bus1.is_word = 1'b0; bus1.addr = 32'd0;
        bus1.b = 32'd0; bus1.mem_rdata = 32'd0;
        bus3.start = 1'b0; bus3.is_word = 1'b0; bus3.addr = 32'd0;
        bus3.b = 32'd0; bus3.mem_rdata = 32'd0;
        test_reset();
        test_byte_lat1();
        test_half_lat3();
        test_word();
        test_start_ignored();
        test_reset_merge();
        test_reset_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
